// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: bit-period limits (also used by the transmitter),
// receiver state encoding and tick counter width.
package rs232_pkg;

   // Last tick index of one bit period at 40 MHz (bit = LIM + 1 clocks)
   localparam int LIM_FAST = 347;    // 115.2 kbps
   localparam int LIM_SLOW = 2083;   // 19.2 kbps

   localparam int TICK_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // Bit-period limit for the selected line rate
   function automatic logic [TICK_W-1:0] rate_lim(input logic fsel);
      return fsel ? TICK_W'(LIM_SLOW) : TICK_W'(LIM_FAST);
   endfunction

endpackage

// File: rtl/rs232_bit_timer.sv
// Bit timer for the RS232 receiver: latches the bit-period limit at frame
// start and counts clocks within the current bit.
import rs232_pkg::*;

module rs232_bit_timer (
   input  logic clk,
   input  logic rst,       // synchronous, active low
   input  logic clr,       // restart the tick count
   input  logic fsel,      // rate select, only looked at while load=1
   input  logic load,      // latch the limit for fsel
   output logic at_half,   // tick is at the centre of a bit
   output logic at_end     // tick is at the last clock of a bit
);

   logic [TICK_W-1:0] lim;
   logic [TICK_W-1:0] tick;

   // Latched rate limit and free-running tick counter
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst) begin
         lim  <= TICK_W'(LIM_FAST);
         tick <= '0;
      end else begin
         if (load)
            lim <= rate_lim(fsel);
         if (clr)
            tick <= '0;
         else
            tick <= tick + TICK_W'(1);
      end
   end

   assign at_half = (tick == (lim >> 1));
   assign at_end  = (tick == lim);

endmodule

// File: rtl/rs232_rx.sv
// RS232 receiver, 8N1, LSB first, 40 MHz clock, 115.2k / 19.2k selectable.
// Bytes are presented on data with a rdy/done handshake.
// Optional macro RS232R_ERR_EN adds the sticky ferr (framing) and ovr
// (overrun) flags; without it those ports are absent and the stop bit
// value is ignored.
import rs232_pkg::*;

module rs232_rx #(
   parameter int SYNC_LEN = 2
) (
   input  logic       clk,
   input  logic       rst,     // synchronous, active low
   input  logic       RxD,     // asynchronous serial line, idles high
   input  logic       fsel,    // 0 = 115.2 kbps, 1 = 19.2 kbps
   input  logic       done,    // consumer has taken data
   output logic [7:0] data,
   output logic       rdy
`ifdef RS232R_ERR_EN
   ,
   output logic       ferr,
   output logic       ovr
`endif
);

   logic [SYNC_LEN-1:0] sync;
   logic                rxs;

   rx_state_e state, state_nxt;
   logic [7:0] shreg;
   logic [2:0] bitcnt;

   logic tmr_clr, tmr_load, at_half, at_end;
   logic shift_en, complete;

   // RxD synchronizer; flops reset to the idle level so reset never looks
   // like a start bit
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here, so it lives inside the clocked
      // block with no reset term in the sensitivity list.
      if (!rst) begin
         sync <= '1;
      end else begin
         sync[0] <= RxD;
         for (int i = 1; i < SYNC_LEN; i++)
            sync[i] <= sync[i-1];
      end
   end

   assign rxs = sync[SYNC_LEN-1];

   rs232_bit_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .fsel    (fsel),
      .load    (tmr_load),
      .at_half (at_half),
      .at_end  (at_end)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and per-cycle controls
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_nxt = state;
      tmr_clr   = 1'b0;
      tmr_load  = 1'b0;
      shift_en  = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            tmr_clr = 1'b1;
            if (!rxs) begin
               tmr_load  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            // A start bit that is high again at its centre was a glitch
            if (at_half) begin
               tmr_clr   = 1'b1;
               state_nxt = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (at_end) begin
               tmr_clr  = 1'b1;
               shift_en = 1'b1;
               if (bitcnt == 3'd7)
                  state_nxt = STOP;
            end
         end
         STOP: begin
            // Leave mid-stop-bit so a following start edge is not missed
            if (at_end) begin
               tmr_clr   = 1'b1;
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            tmr_clr   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Shift register, bit counter, output byte and rdy handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg  <= '0;
         bitcnt <= '0;
         data   <= '0;
         rdy    <= 1'b0;
      end else begin
         if (shift_en) begin
            shreg  <= {rxs, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end else if (state != DATA) begin
            bitcnt <= '0;
         end
         // Completion takes priority over a simultaneous done
         if (complete) begin
            data <= shreg;
            rdy  <= 1'b1;
         end else if (done) begin
            rdy <= 1'b0;
         end
      end
   end

`ifdef RS232R_ERR_EN
   // Sticky framing and overrun flags, cleared by done
   always_ff @(posedge clk) begin
      if (!rst) begin
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end else if (complete) begin
         ferr <= ferr | ~rxs;
         ovr  <= ovr | rdy;
      end else if (done) begin
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// Directed testbench for rs232_rx with a bit-banged transmitter model.
// Build with RS232R_ERR_EN defined to also check ferr/ovr.
`timescale 1ns/1ps

module tb_rs232_rx;

   localparam int BIT_FAST = 348;
   localparam int BIT_SLOW = 2084;

   logic       clk = 1'b0;
   logic       rst;
   logic       RxD;
   logic       fsel;
   logic       done;
   logic [7:0] data;
   logic       rdy;
`ifdef RS232R_ERR_EN
   logic       ferr;
   logic       ovr;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   rs232_rx dut (
      .clk  (clk),
      .rst  (rst),
      .RxD  (RxD),
      .fsel (fsel),
      .done (done),
      .data (data),
      .rdy  (rdy)
`ifdef RS232R_ERR_EN
      ,
      .ferr (ferr),
      .ovr  (ovr)
`endif
   );

   always #12.5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      RxD = v;
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; stop_clks lets a bench shorten a forced-low stop bit
   task automatic send_byte(input logic [7:0] b, input int bit_clks,
                            input logic stop_v, input int stop_clks);
      @(negedge clk);
      hold(1'b0, bit_clks);
      for (int i = 0; i < 8; i++)
         hold(b[i], bit_clks);
      hold(stop_v, stop_clks);
      RxD = 1'b1;
   endtask

   task automatic wait_rdy(input int budget, output int cycles);
      cycles = 0;
      while (!rdy && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (!rdy)
         check("rdy_timeout", {31'd0, rdy}, 32'd1);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   initial begin
      rst  = 1'b0;
      RxD  = 1'b1;
      fsel = 1'b0;
      done = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rdy", {31'd0, rdy}, 32'd0);
      check("reset_data", {24'd0, data}, 32'h00);
`ifdef RS232R_ERR_EN
      check("reset_ferr", {31'd0, ferr}, 32'd0);
      check("reset_ovr", {31'd0, ovr}, 32'd0);
`endif
      rst = 1'b1;
      repeat (20) @(negedge clk);

      // 1: fast 0xA5, latency from the falling start edge
      fork
         send_byte(8'hA5, BIT_FAST, 1'b1, BIT_FAST);
         begin
            @(negedge clk);
            wait_rdy(4000, cyc);
         end
      join
      check("t1_latency_3309pm2", {31'd0, (cyc >= 3307 && cyc <= 3311)}, 32'd1);
      check("t1_data", {24'd0, data}, 32'hA5);
      check("t1_rdy", {31'd0, rdy}, 32'd1);
      pulse_done();
      check("t1_rdy_after_done", {31'd0, rdy}, 32'd0);

      // 3: 100-clock glitch is rejected at the half-bit check
      @(negedge clk);
      hold(1'b0, 100);
      hold(1'b1, 400);
      check("t3_rdy", {31'd0, rdy}, 32'd0);
      check("t3_data_kept", {24'd0, data}, 32'hA5);
      pulse_done();
      check("t3_done_while_idle", {31'd0, rdy}, 32'd0);

      // 4: overrun; second completion coincides with a done pulse
      send_byte(8'h3C, BIT_FAST, 1'b1, BIT_FAST);
      check("t4_first_data", {24'd0, data}, 32'h3C);
      fork
         send_byte(8'h81, BIT_FAST, 1'b1, BIT_FAST);
         begin
            @(negedge clk);
            repeat (3308) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("t4_rdy_completion_wins", {31'd0, rdy}, 32'd1);
            check("t4_data_overwrite", {24'd0, data}, 32'h81);
`ifdef RS232R_ERR_EN
            check("t4_ovr", {31'd0, ovr}, 32'd1);
`endif
         end
      join
      pulse_done();
      check("t4_rdy_cleared", {31'd0, rdy}, 32'd0);
`ifdef RS232R_ERR_EN
      check("t4_ovr_cleared", {31'd0, ovr}, 32'd0);
`endif
      repeat (50) @(negedge clk);

      // 5: stop bit forced low (short, so the line is high by the next half check)
      send_byte(8'h55, BIT_FAST, 1'b0, 200);
      repeat (BIT_FAST) @(negedge clk);
      check("t5_data", {24'd0, data}, 32'h55);
      check("t5_rdy", {31'd0, rdy}, 32'd1);
`ifdef RS232R_ERR_EN
      check("t5_ferr", {31'd0, ferr}, 32'd1);
`endif
      pulse_done();
      check("t5_rdy_cleared", {31'd0, rdy}, 32'd0);
`ifdef RS232R_ERR_EN
      check("t5_ferr_cleared", {31'd0, ferr}, 32'd0);
`endif
      repeat (50) @(negedge clk);

      // 6: reset in the middle of bit 4 of 0xF0 (line high for the rest)
      fork
         send_byte(8'hF0, BIT_FAST, 1'b1, BIT_FAST);
         begin
            @(negedge clk);
            repeat (5 * BIT_FAST + BIT_FAST / 2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
      join
      repeat (400) @(negedge clk);
      check("t6_rdy_after_reset", {31'd0, rdy}, 32'd0);
      check("t6_data_after_reset", {24'd0, data}, 32'h00);
      send_byte(8'h7E, BIT_FAST, 1'b1, BIT_FAST);
      wait_rdy(10, cyc);
      check("t6_data_next", {24'd0, data}, 32'h7E);
      pulse_done();
      repeat (50) @(negedge clk);

      // 7: fsel flips to slow mid-frame; this byte stays at the fast rate
      fork
         send_byte(8'hC3, BIT_FAST, 1'b1, BIT_FAST);
         begin
            repeat (1500) @(negedge clk);
            fsel = 1'b1;
         end
      join
      wait_rdy(10, cyc);
      check("t7_data", {24'd0, data}, 32'hC3);
      pulse_done();
      check("t7_rdy_cleared", {31'd0, rdy}, 32'd0);
      repeat (50) @(negedge clk);

      // 2: slow rate, 0x00 then 0xFF back to back, each consumed by done
      fork
         begin
            send_byte(8'h00, BIT_SLOW, 1'b1, BIT_SLOW);
            send_byte(8'hFF, BIT_SLOW, 1'b1, BIT_SLOW);
         end
         begin
            wait_rdy(25000, cyc);
            check("t2_data_00", {24'd0, data}, 32'h00);
            check("t2_rdy_first", {31'd0, rdy}, 32'd1);
            pulse_done();
            check("t2_rdy_cleared_first", {31'd0, rdy}, 32'd0);
            wait_rdy(25000, cyc);
            check("t2_data_ff", {24'd0, data}, 32'hFF);
            pulse_done();
            check("t2_rdy_cleared_second", {31'd0, rdy}, 32'd0);
         end
      join

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
